// File: rtl/elastic_fifo.sv
// Multi-slot valid/ready FIFO with registered state; ins_ready depends only on occupancy.
// Define ELASTIC_FIFO_BYPASS_EN to let a token pass straight through an empty FIFO.
module elastic_fifo #(
   parameter int DATA_TYPE = 32,
   parameter int NUM_SLOTS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_TYPE-1:0] ins,
   input  logic                 ins_valid,
   output logic                 ins_ready,
   output logic [DATA_TYPE-1:0] outs,
   output logic                 outs_valid,
   input  logic                 outs_ready
);

   localparam int PTR_W = $clog2(NUM_SLOTS);
   localparam int CNT_W = $clog2(NUM_SLOTS + 1);

   logic [NUM_SLOTS-1:0][DATA_TYPE-1:0] storage;
   logic [PTR_W-1:0] head_reg, head_next;
   logic [PTR_W-1:0] tail_reg, tail_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic             empty, full, bypass, wr_en, rd_en;

   assign empty     = (count_reg == '0);
   assign full      = (count_reg == CNT_W'(NUM_SLOTS));
   assign ins_ready = !full;

`ifdef ELASTIC_FIFO_BYPASS_EN
   assign bypass     = empty && ins_valid && outs_ready;
   assign outs_valid = empty ? ins_valid : 1'b1;
   assign outs       = empty ? ins : storage[head_reg];
`else
   assign bypass     = 1'b0;
   assign outs_valid = !empty;
   assign outs       = storage[head_reg];
`endif

   // A bypassed token is consumed directly and never occupies a slot.
   assign wr_en = ins_valid && !full && !bypass;
   assign rd_en = !empty && outs_ready;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
         logic [DATA_TYPE-1:0] slot_reg;
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               slot_reg <= '0;
            else if (wr_en && (tail_reg == PTR_W'(gi)))
               slot_reg <= ins;
         end
         assign storage[gi] = slot_reg;
      end
   endgenerate

   // Explicit wrap so non-power-of-two depths work.
   always_comb begin
      head_next  = head_reg;
      tail_next  = tail_reg;
      count_next = count_reg;
      if (rd_en)
         head_next = (head_reg == PTR_W'(NUM_SLOTS - 1)) ? '0 : head_reg + PTR_W'(1);
      if (wr_en)
         tail_next = (tail_reg == PTR_W'(NUM_SLOTS - 1)) ? '0 : tail_reg + PTR_W'(1);
      case ({wr_en, rd_en})
         2'b10:   count_next = count_reg + CNT_W'(1);
         2'b01:   count_next = count_reg - CNT_W'(1);
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         head_reg  <= head_next;
         tail_reg  <= tail_next;
         count_reg <= count_next;
      end
   end

endmodule

// File: tb/tb_elastic_fifo.sv
// Bench for elastic_fifo: queue-based reference model checked every cycle on depth-4 and depth-3
// instances, plus directed scenarios with hand-computed literal expectations.
module tb_elastic_fifo;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] ins4 = '0, outs4, ins3 = '0, outs3;
   logic        iv4 = 1'b0, ir4, ov4, or4 = 1'b0;
   logic        iv3 = 1'b0, ir3, ov3, or3 = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [31:0] m4[$], m3[$];
   logic [31:0] log4[$], log3[$];
   bit          byp4, rd4, wr4, byp3, rd3, wr3;

   always #5 clk = ~clk;

   elastic_fifo #(.DATA_TYPE(32), .NUM_SLOTS(4)) dut4 (
      .clk(clk), .rst(rst), .ins(ins4), .ins_valid(iv4), .ins_ready(ir4),
      .outs(outs4), .outs_valid(ov4), .outs_ready(or4));

   elastic_fifo #(.DATA_TYPE(32), .NUM_SLOTS(3)) dut3 (
      .clk(clk), .rst(rst), .ins(ins3), .ins_valid(iv3), .ins_ready(ir3),
      .outs(outs3), .outs_valid(ov3), .outs_ready(or3));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: a FIFO is just an ordered queue bounded by its depth.
   always @(posedge clk or posedge rst) begin
      if (rst) m4.delete();
      else begin
         byp4 = 1'b0;
`ifdef ELASTIC_FIFO_BYPASS_EN
         byp4 = (m4.size() == 0) && iv4 && or4;
`endif
         rd4 = (m4.size() != 0) && or4;
         wr4 = iv4 && (m4.size() != 4) && !byp4;
         if (rd4) void'(m4.pop_front());
         if (wr4) m4.push_back(ins4);
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) m3.delete();
      else begin
         byp3 = 1'b0;
`ifdef ELASTIC_FIFO_BYPASS_EN
         byp3 = (m3.size() == 0) && iv3 && or3;
`endif
         rd3 = (m3.size() != 0) && or3;
         wr3 = iv3 && (m3.size() != 3) && !byp3;
         if (rd3) void'(m3.pop_front());
         if (wr3) m3.push_back(ins3);
      end
   end

   // Delivered-token logs taken from the DUT output channel.
   always @(posedge clk) begin
      if (!rst && ov4 && or4) log4.push_back(outs4);
      if (!rst && ov3 && or3) log3.push_back(outs3);
   end

   task automatic cmp_model(input string nm, input int depth, input int sz, input logic [31:0] hd,
                            input logic iv, input logic [31:0] iin,
                            input logic ir, input logic ov, input logic [31:0] o);
      logic        ev;
      logic [31:0] eo;
      ev = (sz != 0);
      eo = hd;
`ifdef ELASTIC_FIFO_BYPASS_EN
      if (sz == 0) begin
         ev = iv;
         eo = iin;
      end
`endif
      chk({nm, ".ins_ready"}, 32'(ir), 32'(sz != depth));
      chk({nm, ".outs_valid"}, 32'(ov), 32'(ev));
      if (ev) chk({nm, ".outs"}, o, eo);
   endtask

   always @(negedge clk) begin
      cmp_model("d4", 4, m4.size(), (m4.size() != 0) ? m4[0] : 32'h0, iv4, ins4, ir4, ov4, outs4);
      cmp_model("d3", 3, m3.size(), (m3.size() != 0) ? m3[0] : 32'h0, iv3, ins3, ir3, ov3, outs3);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain4(input int want);
      int n = 0;
      or4 = 1'b1;
      while (log4.size() < want && n < 50) begin
         step();
         n++;
      end
      chk("drain4_timeout", 32'(log4.size()), 32'(want));
   endtask

   initial begin
      logic [15:0] pat;
      int          idx;
      bit          acc;
      int          cyc;

      // Reset state
      #12;
      chk("rst.ov4", 32'(ov4), 0);
      chk("rst.ir4", 32'(ir4), 1);
      chk("rst.outs4", outs4, 0);
      chk("rst.ov3", 32'(ov3), 0);
      chk("rst.outs3", outs3, 0);
      @(negedge clk);
      #2 rst = 1'b0;
      step();

      // Single token
      log4.delete();
      ins4 = 32'hA5; iv4 = 1'b1; or4 = 1'b1;
`ifdef ELASTIC_FIFO_BYPASS_EN
      chk("single.bypass_ov", 32'(ov4), 1);
      chk("single.bypass_outs", outs4, 32'hA5);
      step();
      iv4 = 1'b0;
`else
      step();
      iv4 = 1'b0;
      chk("single.ov", 32'(ov4), 1);
      chk("single.outs", outs4, 32'hA5);
      step();
`endif
      chk("single.empty_after", 32'(ov4), 0);
      chk("single.log_size", 32'(log4.size()), 1);
      if (log4.size() > 0) chk("single.log0", log4[0], 32'hA5);

      // Fill to full, then read while full
      log4.delete();
      or4 = 1'b0;
      for (int v = 1; v <= 4; v++) begin
         ins4 = 32'(v); iv4 = 1'b1;
         step();
      end
      ins4 = 32'd5;
      chk("full.ir_after4", 32'(ir4), 0);
      step(); step();
      chk("full.ir_held", 32'(ir4), 0);
      chk("full.outs_head", outs4, 1);
      or4 = 1'b1;
      step();
      chk("full_rd.ir_back", 32'(ir4), 1);
      chk("full_rd.outs", outs4, 2);
      step();
      iv4 = 1'b0;
      drain4(5);
      for (int i = 0; i < 5 && i < log4.size(); i++) chk($sformatf("full.seq%0d", i), log4[i], 32'(i + 1));

      // Simultaneous read/write at occupancy 2
      log4.delete();
      or4 = 1'b0; iv4 = 1'b1;
      ins4 = 32'h20; step();
      ins4 = 32'h21; step();
      or4 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         ins4 = 32'h22 + 32'(i);
         step();
         chk($sformatf("simul.ir%0d", i), 32'(ir4), 1);
         chk($sformatf("simul.head%0d", i), outs4, 32'h21 + 32'(i));
      end
      iv4 = 1'b0;
      drain4(10);
      for (int i = 0; i < 10 && i < log4.size(); i++) chk($sformatf("simul.seq%0d", i), log4[i], 32'h20 + 32'(i));

      // Wrap-around on depth 3 with a fixed stall pattern
      log3.delete();
      pat = 16'b1011_0010_1110_0101;
      idx = 0;
      cyc = 0;
      while (log3.size() < 10 && cyc < 200) begin
         ins3 = 32'(idx);
         iv3  = (idx < 10);
         or3  = pat[cyc % 16];
         @(negedge clk);
         acc = iv3 && ir3;
         step();
         if (acc) idx++;
         cyc++;
      end
      iv3 = 1'b0; or3 = 1'b0;
      chk("wrap.count", 32'(log3.size()), 10);
      for (int i = 0; i < 10 && i < log3.size(); i++) chk($sformatf("wrap.seq%0d", i), log3[i], 32'(i));

      // Asynchronous reset mid-stream
      log4.delete();
      or4 = 1'b0; iv4 = 1'b1;
      for (int v = 0; v < 3; v++) begin
         ins4 = 32'h60 + 32'(v);
         step();
      end
      iv4 = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("arst.ov_now", 32'(ov4), 0);
      chk("arst.ir_now", 32'(ir4), 1);
      @(negedge clk);
      #2 rst = 1'b0;
      ins4 = 32'h77; iv4 = 1'b1;
      step();
      iv4 = 1'b0;
      chk("arst.first_ov", 32'(ov4), 1);
      chk("arst.first_outs", outs4, 32'h77);
      drain4(1);
      if (log4.size() > 0) chk("arst.no_stale", log4[0], 32'h77);
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
